fetch_stage: RTL and testbench

- IF stage of the 5-stage MIPS pipeline, directly downstream of the PC calculator.
- Takes the current PC, drives the synchronous instruction SRAM, and absorbs the one-cycle SRAM read latency.
- Buffers the returned instruction while decode is stalled; presents {pc, inst, adel} to decode with a valid/allowin handshake.
- Generates the stall that freezes the PC register.

---
 rtl/cpu_defs.sv | 20 ++
 rtl/fetch_stage_if.sv | 31 +++
 rtl/fs_inst_buf.sv | 35 +++
 rtl/fetch_stage.sv | 118 +++++++++++
 tb/tb_fetch_stage.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_defs.sv
// Shared definitions for the fetch stage slice.
// Contents: reset PC, bubble instruction, fetch-stage state encoding,
// IF->ID bus width and instruction-buffer width.
package cpu_defs;

  localparam logic [31:0] CPU_RESET_PC = 32'hbfc00000;
  localparam logic [31:0] CPU_NOP_INST = 32'h00000000;

  // {pc[31:0], inst[31:0], adel}
  localparam int unsigned FS_TO_DS_BUS_WD = 65;
  // {adel, inst[31:0]}
  localparam int unsigned FS_BUF_WD = 33;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // no entry
    FRESH = 2'd1,  // entry data is on inst_sram_rdata this cycle
    HELD  = 2'd2   // entry data sits in the instruction buffer
  } fs_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction SRAM read port plus the IF->ID
// valid/allowin handshake and presented entry.
// Modports:
//   master - fetch stage side (drives SRAM request and the decode entry)
//   slave  - environment side (SRAM model and decode stage)
interface fetch_stage_if;

  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;
  logic        ds_allowin;
  logic        fs_to_ds_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;
  logic        fs_adel;

  modport master (
    output inst_sram_en, inst_sram_addr,
    input  inst_sram_rdata,
    input  ds_allowin,
    output fs_to_ds_valid, fs_pc, fs_inst, fs_adel
  );

  modport slave (
    input  inst_sram_en, inst_sram_addr,
    output inst_sram_rdata,
    output ds_allowin,
    input  fs_to_ds_valid, fs_pc, fs_inst, fs_adel
  );

endinterface

// File: rtl/fs_inst_buf.sv
// Instruction buffer for the fetch stage: a load-enabled register holding
// {adel, inst}, plus the selection between the live SRAM-derived entry and
// the buffered copy.
// Ports:
//   clk, resetn  - clock, synchronous active-low reset (buffer clears to 0)
//   load         - capture fresh into the buffer
//   sel_fresh    - present fresh instead of the buffered entry
//   fresh        - {adel, inst} derived from the SRAM output this cycle
//   entry        - selected {adel, inst}
module fs_inst_buf
  import cpu_defs::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 load,
  input  logic                 sel_fresh,
  input  logic [FS_BUF_WD-1:0] fresh,
  output logic [FS_BUF_WD-1:0] entry
);

  logic [FS_BUF_WD-1:0] buf_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      buf_q <= '0;
    end else if (load) begin
      buf_q <= fresh;
    end
  end

  always_comb begin
    entry = sel_fresh ? fresh : buf_q;
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline.
// Issues instruction SRAM reads for fe_pc, absorbs the one-cycle SRAM
// latency, buffers the returned instruction while decode stalls and
// presents {pc, inst, adel} to decode under a valid/allowin handshake.
// pc_stall freezes the upstream PC register when no request is issued.
// Ports:
//   clk, resetn  - clock, synchronous active-low reset
//   fe_pc        - PC to fetch
//   flush        - drop the in-flight fetch and any held entry
//   pc_stall     - hold the PC register this cycle
//   bus          - fetch_stage_if.master: SRAM port and IF->ID entry
// Build option: define FS_ADEL_CHECK_EN to flag misaligned fetch PCs
// (no SRAM access, NOP presented with fs_adel=1); otherwise every request
// reads the SRAM and fs_adel stays 0.
module fetch_stage
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = CPU_RESET_PC,
  parameter logic [31:0] NOP_INST = CPU_NOP_INST
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [31:0]          fe_pc,
  input  logic                 flush,
  output logic                 pc_stall,
  fetch_stage_if.master        bus
);

  fs_state_e            state, state_nxt;
  logic [31:0]          pc_q;
  logic                 adel_q;
  logic                 adel_now;
  logic                 valid;
  logic                 hs;
  logic                 req;
  logic                 buf_load;
  logic [FS_BUF_WD-1:0] fresh_entry;
  logic [FS_BUF_WD-1:0] entry;
  logic [FS_TO_DS_BUS_WD-1:0] fs_bus;

`ifdef FS_ADEL_CHECK_EN
  assign adel_now = (fe_pc[1:0] != 2'b00);
`else
  assign adel_now = 1'b0;
`endif

  always_comb begin
    valid    = (state != EMPTY) & ~flush;
    hs       = valid & bus.ds_allowin;
    // A new request goes out in the same cycle the current entry is taken,
    // giving one instruction per cycle when decode never stalls.
    req      = resetn & ~flush & ((state == EMPTY) | hs);
    pc_stall = resetn & ~flush & ~req;
    // SRAM output only stays valid for one cycle, so a stalled FRESH entry
    // must be captured before it disappears.
    buf_load = resetn & ~flush & (state == FRESH) & ~bus.ds_allowin;
  end

  always_comb begin
    state_nxt = state;
    if (!resetn || flush) begin
      state_nxt = EMPTY;
    end else if (req) begin
      state_nxt = FRESH;
    end else begin
      unique case (state)
        FRESH: begin
          if (hs) begin
            state_nxt = EMPTY;
          end else if (!bus.ds_allowin) begin
            state_nxt = HELD;
          end
        end
        HELD:    state_nxt = HELD;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= EMPTY;
      pc_q   <= RESET_PC;
      adel_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (req) begin
        pc_q   <= fe_pc;
        adel_q <= adel_now;
      end
    end
  end

  always_comb begin
    fresh_entry = {adel_q, (adel_q ? NOP_INST : bus.inst_sram_rdata)};
  end

  fs_inst_buf u_inst_buf (
    .clk       (clk),
    .resetn    (resetn),
    .load      (buf_load),
    .sel_fresh (state == FRESH),
    .fresh     (fresh_entry),
    .entry     (entry)
  );

  always_comb begin
    fs_bus = {pc_q, entry[31:0], entry[32]};
  end

  assign bus.inst_sram_en   = req & ~adel_now;
  assign bus.inst_sram_addr = fe_pc;
  assign bus.fs_to_ds_valid = valid;
  assign bus.fs_pc          = fs_bus[64:33];
  assign bus.fs_inst        = fs_bus[32:1];
  assign bus.fs_adel        = fs_bus[0];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, streaming, decode stall with
// buffering, flush, misaligned PC and reset while holding an entry.
module tb_fetch_stage;

  logic        clk;
  logic        resetn;
  logic [31:0] fe_pc;
  logic        flush;
  logic        pc_stall;

  int unsigned n_tests;
  int unsigned n_fail;

  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_PC (32'hbfc00000),
    .NOP_INST (32'h00000000)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .fe_pc    (fe_pc),
    .flush    (flush),
    .pc_stall (pc_stall),
    .bus      (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle: inputs change 1 time unit after the rising edge,
  // outputs are then sampled mid-cycle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    resetn  = 1'b0;
    fe_pc   = 32'hbfc00000;
    flush   = 1'b0;
    bus.ds_allowin      = 1'b1;
    bus.inst_sram_rdata = 32'h0;

    next_cycle();
    next_cycle();
    settle();
    chk("rst_valid", {31'b0, bus.fs_to_ds_valid}, 32'd0);
    chk("rst_en", {31'b0, bus.inst_sram_en}, 32'd0);
    chk("rst_stall", {31'b0, pc_stall}, 32'd0);
    chk("rst_pc", bus.fs_pc, 32'hbfc00000);
    chk("rst_adel", {31'b0, bus.fs_adel}, 32'd0);
    chk("rst_inst", bus.fs_inst, 32'h0);

    // cycle 0: first request
    next_cycle();
    resetn = 1'b1;
    settle();
    chk("c0_en", {31'b0, bus.inst_sram_en}, 32'd1);
    chk("c0_addr", bus.inst_sram_addr, 32'hbfc00000);
    chk("c0_stall", {31'b0, pc_stall}, 32'd0);
    chk("c0_valid", {31'b0, bus.fs_to_ds_valid}, 32'd0);

    // cycle 1: first entry presented, next request
    next_cycle();
    fe_pc = 32'hbfc00004;
    bus.inst_sram_rdata = 32'h11111111;
    settle();
    chk("c1_valid", {31'b0, bus.fs_to_ds_valid}, 32'd1);
    chk("c1_pc", bus.fs_pc, 32'hbfc00000);
    chk("c1_inst", bus.fs_inst, 32'h11111111);
    chk("c1_adel", {31'b0, bus.fs_adel}, 32'd0);
    chk("c1_en", {31'b0, bus.inst_sram_en}, 32'd1);
    chk("c1_addr", bus.inst_sram_addr, 32'hbfc00004);
    chk("c1_stall", {31'b0, pc_stall}, 32'd0);

    // cycle 2: streaming
    next_cycle();
    fe_pc = 32'hbfc00008;
    bus.inst_sram_rdata = 32'h22222222;
    settle();
    chk("c2_pc", bus.fs_pc, 32'hbfc00004);
    chk("c2_inst", bus.fs_inst, 32'h22222222);
    chk("c2_stall", {31'b0, pc_stall}, 32'd0);
    chk("c2_en", {31'b0, bus.inst_sram_en}, 32'd1);

    // cycle 3: decode stalls while FRESH
    next_cycle();
    fe_pc = 32'hbfc0000c;
    bus.inst_sram_rdata = 32'h24080001;
    bus.ds_allowin = 1'b0;
    settle();
    chk("c3_valid", {31'b0, bus.fs_to_ds_valid}, 32'd1);
    chk("c3_pc", bus.fs_pc, 32'hbfc00008);
    chk("c3_inst", bus.fs_inst, 32'h24080001);
    chk("c3_stall", {31'b0, pc_stall}, 32'd1);
    chk("c3_en", {31'b0, bus.inst_sram_en}, 32'd0);

    // cycles 4,5: HELD, SRAM output changes underneath
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      bus.inst_sram_rdata = 32'hdeadbeef;
      settle();
      chk("held_inst", bus.fs_inst, 32'h24080001);
      chk("held_pc", bus.fs_pc, 32'hbfc00008);
      chk("held_stall", {31'b0, pc_stall}, 32'd1);
      chk("held_en", {31'b0, bus.inst_sram_en}, 32'd0);
      chk("held_valid", {31'b0, bus.fs_to_ds_valid}, 32'd1);
    end

    // cycle 6: release, handshake and new request together
    next_cycle();
    bus.ds_allowin = 1'b1;
    settle();
    chk("c6_inst", bus.fs_inst, 32'h24080001);
    chk("c6_en", {31'b0, bus.inst_sram_en}, 32'd1);
    chk("c6_addr", bus.inst_sram_addr, 32'hbfc0000c);
    chk("c6_stall", {31'b0, pc_stall}, 32'd0);

    // cycle 7: stall again to reach HELD
    next_cycle();
    fe_pc = 32'hbfc00010;
    bus.inst_sram_rdata = 32'h33333333;
    bus.ds_allowin = 1'b0;
    settle();
    chk("c7_pc", bus.fs_pc, 32'hbfc0000c);
    chk("c7_inst", bus.fs_inst, 32'h33333333);
    chk("c7_stall", {31'b0, pc_stall}, 32'd1);

    // cycle 8: flush while HELD
    next_cycle();
    flush = 1'b1;
    bus.ds_allowin = 1'b1;
    bus.inst_sram_rdata = 32'hdeadbeef;
    settle();
    chk("fl_valid", {31'b0, bus.fs_to_ds_valid}, 32'd0);
    chk("fl_stall", {31'b0, pc_stall}, 32'd0);
    chk("fl_en", {31'b0, bus.inst_sram_en}, 32'd0);

    // cycle 9: EMPTY, request at redirect target; stale response ignored
    next_cycle();
    flush = 1'b0;
    fe_pc = 32'hbfc00100;
    bus.inst_sram_rdata = 32'h55555555;
    settle();
    chk("c9_valid", {31'b0, bus.fs_to_ds_valid}, 32'd0);
    chk("c9_en", {31'b0, bus.inst_sram_en}, 32'd1);
    chk("c9_addr", bus.inst_sram_addr, 32'hbfc00100);
    chk("c9_stall", {31'b0, pc_stall}, 32'd0);

    // cycle 10: misaligned PC requested
    next_cycle();
    fe_pc = 32'hbfc00002;
    bus.inst_sram_rdata = 32'h66666666;
    settle();
    chk("c10_pc", bus.fs_pc, 32'hbfc00100);
    chk("c10_inst", bus.fs_inst, 32'h66666666);
    chk("c10_stall", {31'b0, pc_stall}, 32'd0);
`ifdef FS_ADEL_CHECK_EN
    chk("c10_en", {31'b0, bus.inst_sram_en}, 32'd0);
`else
    chk("c10_en", {31'b0, bus.inst_sram_en}, 32'd1);
`endif

    // cycle 11: misaligned entry presented, decode stalls
    next_cycle();
    fe_pc = 32'hbfc00004;
    bus.inst_sram_rdata = 32'h77777777;
    bus.ds_allowin = 1'b0;
    settle();
    chk("c11_valid", {31'b0, bus.fs_to_ds_valid}, 32'd1);
    chk("c11_pc", bus.fs_pc, 32'hbfc00002);
    chk("c11_stall", {31'b0, pc_stall}, 32'd1);
`ifdef FS_ADEL_CHECK_EN
    chk("c11_adel", {31'b0, bus.fs_adel}, 32'd1);
    chk("c11_inst", bus.fs_inst, 32'h00000000);
`else
    chk("c11_adel", {31'b0, bus.fs_adel}, 32'd0);
    chk("c11_inst", bus.fs_inst, 32'h77777777);
`endif

    // cycle 12: HELD, reset asserted
    next_cycle();
    bus.inst_sram_rdata = 32'hdeadbeef;
    resetn = 1'b0;
    settle();
`ifdef FS_ADEL_CHECK_EN
    chk("c12_inst", bus.fs_inst, 32'h00000000);
    chk("c12_adel", {31'b0, bus.fs_adel}, 32'd1);
`else
    chk("c12_inst", bus.fs_inst, 32'h77777777);
    chk("c12_adel", {31'b0, bus.fs_adel}, 32'd0);
`endif
    chk("c12_en", {31'b0, bus.inst_sram_en}, 32'd0);
    chk("c12_stall", {31'b0, pc_stall}, 32'd0);

    // cycle 13: back to reset state
    next_cycle();
    settle();
    chk("c13_valid", {31'b0, bus.fs_to_ds_valid}, 32'd0);
    chk("c13_pc", bus.fs_pc, 32'hbfc00000);
    chk("c13_en", {31'b0, bus.inst_sram_en}, 32'd0);
    chk("c13_adel", {31'b0, bus.fs_adel}, 32'd0);

    // cycle 14: restart fetching
    next_cycle();
    resetn = 1'b1;
    bus.ds_allowin = 1'b1;
    settle();
    chk("c14_en", {31'b0, bus.inst_sram_en}, 32'd1);
    chk("c14_addr", bus.inst_sram_addr, 32'hbfc00004);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
